// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register-file geometry and the write-back
// data source select table used by both control and datapath.
package mips_pkg;

  localparam int          DATA_W   = 32;
  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [4:0]  REG_SP   = 5'd29;
  localparam logic [31:0] SP_RESET = 32'd227;

  // Write-back data source select; the encoding is shared with the control unit.
  typedef enum logic [3:0] {
    SRC_ALU   = 4'd0,
    SRC_MEM   = 4'd1,
    SRC_PC4   = 4'd2,
    SRC_HI    = 4'd3,
    SRC_LO    = 4'd4,
    SRC_LUI   = 4'd5,
    SRC_SHIFT = 4'd6,
    SRC_CMP   = 4'd7,
    SRC_9     = 4'd8
  } src_sel_e;

  function automatic logic is_zero_reg(input logic [4:0] addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/reg_bank_read_port.sv
// One combinational register-file read port: register 0 is forced to zero and,
// when enabled, a same-cycle write to the addressed register is forwarded.
module reg_read_port #(
  parameter int DATA_W = 32,
  parameter int BYPASS = 1
) (
  input  logic [4:0]        read_reg,
  input  logic [DATA_W-1:0] stored,
  input  logic              reg_write,
  input  logic [4:0]        write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data
);
  import mips_pkg::*;

  logic hit;

  assign hit = reg_write && (write_reg == read_reg) && !is_zero_reg(write_reg);

  always_comb begin
    read_data = '0;
    if (!is_zero_reg(read_reg)) begin
      if ((BYPASS != 0) && hit) read_data = write_data;
      else                      read_data = stored;
    end
  end

endmodule

// File: rtl/reg_bank.sv
// Architectural register file: 32 GPRs with two read ports plus the HI/LO pair,
// fed by the write-back data source selector.
module reg_bank #(
  parameter int              DATA_W   = mips_pkg::DATA_W,
  parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(mips_pkg::SP_RESET),
  parameter int              BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write,
  input  logic [4:0]        write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [4:0]        read_reg1,
  input  logic [4:0]        read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              hilo_write,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              wr_ack
);
  import mips_pkg::*;

  logic [DATA_W-1:0] gpr [32];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  // GPR array; entry 0 is held at zero and never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++)
        gpr[i] <= (i == int'(REG_SP)) ? SP_RESET : '0;
    end else if (reg_write && !is_zero_reg(write_reg)) begin
      gpr[write_reg] <= write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (hilo_write) begin
      hi_q <= hi_in;
      lo_q <= lo_in;
    end
  end

  // Acknowledges every accepted commit, including the dropped write to reg 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_ack <= 1'b0;
    else        wr_ack <= reg_write;
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

  reg_read_port #(
    .DATA_W (DATA_W),
    .BYPASS (BYPASS)
  ) u_port_rs (
    .read_reg   (read_reg1),
    .stored     (gpr[read_reg1]),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_data  (read_data1)
  );

  reg_read_port #(
    .DATA_W (DATA_W),
    .BYPASS (BYPASS)
  ) u_port_rt (
    .read_reg   (read_reg2),
    .stored     (gpr[read_reg2]),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_data  (read_data2)
  );

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Architectural register file for the multicycle MIPS datapath: the consumer end of the write-back data source selector.
- Holds 32 GPRs plus the HI/LO pair.
- Accepts one write per cycle from the selected write-back data.
- Serves two combinational read ports (rs/rt) with optional write-through bypass.

Parameters:
- DATA_W, 32, register width in bits.
- SP_RESET, 32'd227, reset value of register 29 ($sp).
- BYPASS, 1, 1 = a read of the register being written this cycle returns the write data; 0 = returns the stored value.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- reg_write  in  1  GPR write enable.
- write_reg  in  5  GPR write address (from the RegDst selector).
- write_data  in  DATA_W  write-back value (output of the data source selector).
- read_reg1  in  5  rs address.
- read_reg2  in  5  rt address.
- read_data1  out  DATA_W  rs value.
- read_data2  out  DATA_W  rt value.
- hilo_write  in  1  HI/LO write enable.
- hi_in  in  DATA_W  next HI value.
- lo_in  in  DATA_W  next LO value.
- hi_out  out  DATA_W  current HI.
- lo_out  out  DATA_W  current LO.
- wr_ack  out  1  registered pulse: a GPR write committed last edge.

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n), applied immediately on assertion, released synchronously to clk by the top level.
- Reset values:
  - All GPRs 0, except reg 29 = SP_RESET.
  - HI = LO = 0.
  - wr_ack = 0.
  - read_data1/2 reflect the reset contents combinationally (read_data of reg 29 = SP_RESET during reset).
- Write:
  - On a rising edge with reg_write=1 and write_reg != 0, GPR[write_reg] <= write_data.
  - Latency one edge.
- Register 0:
  - Writes are discarded.
  - Reads always return 0, including under bypass.
  - wr_ack still pulses for a write to reg 0 (the commit was accepted and dropped).
- Read:
  - Purely combinational from the addresses; no clock latency.
  - BYPASS=1: if reg_write=1, write_reg == read_regN and write_reg != 0, read_dataN = write_data in the same cycle.
  - BYPASS=0: read_dataN = stored value; the new value is visible after the edge.
- Both read ports may address the same register; both return the identical value.
- HI/LO:
  - On a rising edge with hilo_write=1, HI <= hi_in and LO <= lo_in in the same edge.
  - Never partially updated.
  - No bypass; hi_out/lo_out are registered values.
- Simultaneous reg_write and hilo_write are independent; both commit on the same edge.
- wr_ack <= reg_write on each edge, so it is high for exactly the cycle after each write edge.
- Reset mid-operation: asserting rst_n=0 in a cycle where reg_write=1 discards the write. Contents return to reset values regardless of the clock.
- No X propagation: addresses are full 5-bit decode, all 32 entries valid.

Decomposition:
- Shared package (mips_pkg): DATA_W, REG_ZERO=5'd0, REG_SP=5'd29, SP_RESET.
- Same package: the 4-bit data source select encodings (SRC_ALU=0 … SRC_9=8), so control and datapath agree on one table.
- One natural sub-module: reg_read_port, one combinational read with zero-gating and bypass, instantiated twice.
- HI/LO and the GPR array stay in the top.

Test Plan:
- Reset: assert rst_n=0 mid-cycle, read_reg1=29, read_reg2=5 -> read_data1=227, read_data2=0 immediately; hi_out=lo_out=0; wr_ack=0.
- Basic write/read: reg_write=1, write_reg=8, write_data=0xDEADBEEF, one edge -> read_reg1=8 gives 0xDEADBEEF; wr_ack=1 for exactly one cycle.
- Register 0: write 0x12345678 to reg 0 -> read of reg 0 returns 0 before and after the edge, also with BYPASS=1 in the write cycle.
- Bypass:
  - BYPASS=1, reg 9 holds 0x1, same-cycle write of 0x55 to reg 9 while read_reg2=9 -> read_data2=0x55 before the edge.
  - BYPASS=0 -> read_data2=0x1 until the edge, then 0x55.
- HI/LO plus concurrent GPR write: hilo_write=1, hi_in=0xAAAA0000, lo_in=0x0000BBBB, reg_write=1 to reg 3 = 7 on the same edge -> hi_out=0xAAAA0000, lo_out=0x0000BBBB, reg 3=7.
- Reset during write: reg_write=1, write_reg=29, write_data=0, then rst_n=0 before the edge -> reg 29 reads 227 after the edge, wr_ack=0.
